multicycle_control_unit: RTL and testbench



---
 rtl/multicycle_control_unit_if.sv | 40 ++++
 rtl/multicycle_control_unit.sv | 209 ++++++++++++++++++++
 tb/tb_multicycle_control_unit.sv | 259 +++++++++++++++++++++++++
 3 files changed

// File: rtl/multicycle_control_unit_if.sv
// Control bundle between the multicycle control unit and the datapath/memories.
// master = control unit side, slave = datapath/memory side.
interface multicycle_control_unit_if #(
    parameter int CNT_W = 32
);
    logic [6:0]       opcode;
    logic [2:0]       funct3;
    logic [6:0]       funct7;
    logic             imem_ready;
    logic             dmem_ready;
    logic             trap_clr;
    logic             imem_req;
    logic             ir_wr;
    logic             pc_wr;
    logic             dmem_req;
    logic             AluaSrc;
    logic             AlubSrc;
    logic [2:0]       immsrc;
    logic [3:0]       AluOp;
    logic [4:0]       BrOp;
    logic             DMWr;
    logic [2:0]       DMCTrl;
    logic             RuWr;
    logic [1:0]       RuDataWrSrc;
    logic             trap;
    logic [1:0]       trap_cause;
    logic [CNT_W-1:0] instret;

    modport master (
        input  opcode, funct3, funct7, imem_ready, dmem_ready, trap_clr,
        output imem_req, ir_wr, pc_wr, dmem_req, AluaSrc, AlubSrc, immsrc, AluOp,
               BrOp, DMWr, DMCTrl, RuWr, RuDataWrSrc, trap, trap_cause, instret
    );

    modport slave (
        output opcode, funct3, funct7, imem_ready, dmem_ready, trap_clr,
        input  imem_req, ir_wr, pc_wr, dmem_req, AluaSrc, AlubSrc, immsrc, AluOp,
               BrOp, DMWr, DMCTrl, RuWr, RuDataWrSrc, trap, trap_cause, instret
    );
endinterface

// File: rtl/multicycle_control_unit.sv
// Multicycle RV32I control unit: FETCH/DECODE/EXEC/MEM/WB sequencing with
// variable-latency memory handshakes, memory watchdog, illegal-opcode trap and instret.
module multicycle_control_unit #(
    parameter int TIMEOUT_CYCLES  = 16,
    parameter int CNT_W           = 32,
    parameter bit TRAP_ON_ILLEGAL = 1'b1
) (
    input logic clk,
    input logic rst,
    multicycle_control_unit_if.master bus
);
    localparam int WAIT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT_CYCLES - 1);

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_FENCE  = 7'b0001111;

    typedef enum logic [2:0] {
        S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_TRAP
    } state_t;

    state_t            state, state_n;
    logic [WAIT_W-1:0] wait_cnt;
    logic [1:0]        cause, cause_n;
    logic [CNT_W-1:0]  instret_q;

    logic is_r, is_opimm, is_load, is_store, is_branch;
    logic is_jal, is_jalr, is_lui, is_auipc, is_fence, is_legal;

    logic       alua_d, alub_d;
    logic [2:0] immsrc_d, dmctrl_d;
    logic [3:0] aluop_d;
    logic [4:0] brop_d;
    logic [1:0] wbsrc_d;
    logic       dec_en;

    logic imem_req, ir_wr, pc_wr, dmem_req, dmwr, ruwr;
    logic unused_funct7;

    assign unused_funct7 = ^{bus.funct7[6], bus.funct7[4:0]};

    assign is_r      = (bus.opcode == OP_R);
    assign is_opimm  = (bus.opcode == OP_IMM);
    assign is_load   = (bus.opcode == OP_LOAD);
    assign is_store  = (bus.opcode == OP_STORE);
    assign is_branch = (bus.opcode == OP_BRANCH);
    assign is_jal    = (bus.opcode == OP_JAL);
    assign is_jalr   = (bus.opcode == OP_JALR);
    assign is_lui    = (bus.opcode == OP_LUI);
    assign is_auipc  = (bus.opcode == OP_AUIPC);
    assign is_fence  = (bus.opcode == OP_FENCE);
    assign is_legal  = is_r | is_opimm | is_load | is_store | is_branch |
                       is_jal | is_jalr | is_lui | is_auipc | is_fence;

    always_comb begin
        alua_d   = 1'b0;
        alub_d   = ~is_r;
        immsrc_d = 3'b000;
        aluop_d  = 4'b0000;
        brop_d   = 5'b00000;
        dmctrl_d = 3'b011;
        wbsrc_d  = 2'b00;
        if (is_r) aluop_d = {bus.funct7[5], bus.funct3};
        // Only SRAI among the immediate ops takes its variant bit from funct7.
        if (is_opimm) aluop_d = (bus.funct3 == 3'b101) ? {bus.funct7[5], 3'b101}
                                                       : {1'b0, bus.funct3};
        if (is_lui) begin
            immsrc_d = 3'b010;
            aluop_d  = 4'b1011;
        end
        if (is_auipc) begin
            immsrc_d = 3'b010;
            alua_d   = 1'b1;
        end
        if (is_store) begin
            immsrc_d = 3'b001;
            dmctrl_d = bus.funct3;
        end
        if (is_load) begin
            dmctrl_d = bus.funct3;
            wbsrc_d  = 2'b01;
        end
        if (is_branch) begin
            immsrc_d = 3'b101;
            alua_d   = 1'b1;
            brop_d   = {2'b01, bus.funct3};
        end
        if (is_jal) begin
            immsrc_d = 3'b110;
            alua_d   = 1'b1;
            brop_d   = 5'b10000;
            wbsrc_d  = 2'b10;
        end
        if (is_jalr) begin
            brop_d  = 5'b10000;
            wbsrc_d = 2'b10;
        end
    end

    always_comb begin
        state_n  = state;
        cause_n  = cause;
        imem_req = 1'b0;
        ir_wr    = 1'b0;
        pc_wr    = 1'b0;
        dmem_req = 1'b0;
        dmwr     = 1'b0;
        ruwr     = 1'b0;
        case (state)
            S_FETCH: begin
                imem_req = 1'b1;
                // ir_wr is masked while rst is high so an abort never loads the IR.
                if (bus.imem_ready) begin
                    ir_wr   = ~rst;
                    state_n = S_DECODE;
                end else if (wait_cnt == WAIT_LAST) begin
                    state_n = S_TRAP;
                    cause_n = 2'b10;
                end
            end
            S_DECODE: begin
                if (!is_legal && TRAP_ON_ILLEGAL) begin
                    state_n = S_TRAP;
                    cause_n = 2'b01;
                end else begin
                    state_n = S_EXEC;
                end
            end
            S_EXEC: begin
                if (is_load || is_store) begin
                    state_n = S_MEM;
                end else if (is_branch || is_fence || !is_legal) begin
                    pc_wr   = 1'b1;
                    state_n = S_FETCH;
                end else begin
                    state_n = S_WB;
                end
            end
            S_MEM: begin
                dmem_req = 1'b1;
                dmwr     = is_store;
                if (bus.dmem_ready) begin
                    pc_wr   = is_store;
                    state_n = is_store ? S_FETCH : S_WB;
                end else if (wait_cnt == WAIT_LAST) begin
                    state_n = S_TRAP;
                    cause_n = 2'b11;
                end
            end
            S_WB: begin
                ruwr    = 1'b1;
                pc_wr   = 1'b1;
                state_n = S_FETCH;
            end
            S_TRAP: begin
                if (bus.trap_clr) begin
                    state_n = S_FETCH;
                    cause_n = 2'b00;
                end
            end
            default: state_n = S_FETCH;
        endcase
    end

    // The wait counter restarts on every state change, so it only ever
    // accumulates while FETCH or MEM is stalled on its ready.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_FETCH;
            wait_cnt  <= '0;
            cause     <= 2'b00;
            instret_q <= '0;
        end else begin
            state <= state_n;
            cause <= cause_n;
            if (pc_wr) instret_q <= instret_q + CNT_W'(1);
            if (state_n != state) wait_cnt <= '0;
            else if (state == S_FETCH || state == S_MEM) wait_cnt <= wait_cnt + WAIT_W'(1);
        end
    end

    assign dec_en = (state == S_DECODE) || (state == S_EXEC) ||
                    (state == S_MEM) || (state == S_WB);

    assign bus.imem_req    = imem_req;
    assign bus.ir_wr       = ir_wr;
    assign bus.pc_wr       = pc_wr;
    assign bus.dmem_req    = dmem_req;
    assign bus.DMWr        = dmwr;
    assign bus.RuWr        = ruwr;
    assign bus.AluaSrc     = dec_en & alua_d;
    assign bus.AlubSrc     = dec_en & alub_d;
    assign bus.immsrc      = dec_en ? immsrc_d : 3'b000;
    assign bus.AluOp       = dec_en ? aluop_d  : 4'b0000;
    assign bus.BrOp        = dec_en ? brop_d   : 5'b00000;
    assign bus.DMCTrl      = dec_en ? dmctrl_d : 3'b000;
    assign bus.RuDataWrSrc = dec_en ? wbsrc_d  : 2'b00;
    assign bus.trap        = (state == S_TRAP);
    assign bus.trap_cause  = cause;
    assign bus.instret     = instret_q;
endmodule

// File: tb/tb_multicycle_control_unit.sv
// Self-checking bench: directed and randomized instructions compared cycle by cycle
// against a timeline model built from the instruction class and memory latencies.
module tb_multicycle_control_unit;
    localparam int TO    = 4;
    localparam int CNT_W = 32;

    typedef struct packed {
        logic       AluaSrc;
        logic       AlubSrc;
        logic [2:0] immsrc;
        logic [3:0] AluOp;
        logic [4:0] BrOp;
        logic [2:0] DMCTrl;
        logic [1:0] wsrc;
    } dec_t;

    typedef enum {K_WB, K_LOAD, K_STORE, K_PCEXEC, K_ILLEGAL} kind_t;

    // Strobe vector order: {imem_req, ir_wr, pc_wr, dmem_req, DMWr, RuWr, trap}
    localparam logic [6:0] X_IDLE    = 7'b0000000;
    localparam logic [6:0] X_FWAIT   = 7'b1000000;
    localparam logic [6:0] X_FDONE   = 7'b1100000;
    localparam logic [6:0] X_PC      = 7'b0010000;
    localparam logic [6:0] X_WB      = 7'b0010010;
    localparam logic [6:0] X_LDMEM   = 7'b0001000;
    localparam logic [6:0] X_STMEM   = 7'b0001100;
    localparam logic [6:0] X_STDONE  = 7'b0011100;
    localparam logic [6:0] X_TRAP    = 7'b0000001;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int checks = 0;
    int errors = 0;

    logic [6:0]       cur_op = '0;
    logic [2:0]       cur_f3 = '0;
    logic [6:0]       cur_f7 = '0;
    dec_t             cur_dec = '0;
    logic [1:0]       cur_cause = 2'b00;
    logic [CNT_W-1:0] exp_ret = '0;

    multicycle_control_unit_if #(.CNT_W(CNT_W)) bus ();

    multicycle_control_unit #(
        .TIMEOUT_CYCLES (TO),
        .CNT_W          (CNT_W),
        .TRAP_ON_ILLEGAL(1'b1)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus.master)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: observed no finish, expected finish before 100000");
        $fatal(1, "[TB] simulation time limit exceeded");
    end

    function automatic dec_t ref_decode(input logic [6:0] op, input logic [2:0] f3,
                                        input logic [6:0] f7);
        dec_t d;
        d = '{AluaSrc: 1'b0, AlubSrc: 1'b1, immsrc: 3'b000, AluOp: 4'b0000,
              BrOp: 5'b00000, DMCTrl: 3'b011, wsrc: 2'b00};
        case (op)
            7'b0110011: begin d.AlubSrc = 1'b0; d.AluOp = {f7[5], f3}; end
            7'b0010011: d.AluOp = (f3 == 3'b101) ? {f7[5], 3'b101} : {1'b0, f3};
            7'b0000011: begin d.DMCTrl = f3; d.wsrc = 2'b01; end
            7'b0100011: begin d.immsrc = 3'b001; d.DMCTrl = f3; end
            7'b1100011: begin d.immsrc = 3'b101; d.AluaSrc = 1'b1; d.BrOp = {2'b01, f3}; end
            7'b1101111: begin
                d.immsrc = 3'b110; d.AluaSrc = 1'b1; d.BrOp = 5'b10000; d.wsrc = 2'b10;
            end
            7'b1100111: begin d.BrOp = 5'b10000; d.wsrc = 2'b10; end
            7'b0110111: begin d.immsrc = 3'b010; d.AluOp = 4'b1011; end
            7'b0010111: begin d.immsrc = 3'b010; d.AluaSrc = 1'b1; end
            default: ;
        endcase
        return d;
    endfunction

    function automatic kind_t classify(input logic [6:0] op);
        case (op)
            7'b0000011: return K_LOAD;
            7'b0100011: return K_STORE;
            7'b1100011, 7'b0001111: return K_PCEXEC;
            7'b0110011, 7'b0010011, 7'b0110111, 7'b0010111, 7'b1101111, 7'b1100111:
                return K_WB;
            default: return K_ILLEGAL;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input logic ir, input logic dr, input logic clr);
        @(negedge clk);
        bus.opcode     = cur_op;
        bus.funct3     = cur_f3;
        bus.funct7     = cur_f7;
        bus.imem_ready = ir;
        bus.dmem_ready = dr;
        bus.trap_clr   = clr;
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [6:0] exp_s, input dec_t exp_d);
        logic [6:0] obs_s;
        dec_t       obs_d;
        obs_s = {bus.imem_req, bus.ir_wr, bus.pc_wr, bus.dmem_req, bus.DMWr, bus.RuWr, bus.trap};
        obs_d = '{AluaSrc: bus.AluaSrc, AlubSrc: bus.AlubSrc, immsrc: bus.immsrc,
                  AluOp: bus.AluOp, BrOp: bus.BrOp, DMCTrl: bus.DMCTrl, wsrc: bus.RuDataWrSrc};
        chk({tag, ".strobes"}, 64'(obs_s), 64'(exp_s));
        chk({tag, ".decode"}, 64'(obs_d), 64'(exp_d));
        chk({tag, ".cause"}, 64'(bus.trap_cause), 64'(cur_cause));
        chk({tag, ".instret"}, 64'(bus.instret), 64'(exp_ret));
    endtask

    task automatic step(input string tag, input logic ir, input logic dr, input logic clr,
                        input logic [6:0] exp_s, input logic dec_on);
        applyStimulus(ir, dr, clr);
        checkOutput(tag, exp_s, dec_on ? cur_dec : dec_t'('0));
        if (exp_s[4]) exp_ret++;
    endtask

    function automatic logic rb();
        return 1'($urandom_range(0, 1));
    endfunction

    task automatic do_trap(input logic [1:0] cause);
        int n;
        cur_cause = cause;
        n = $urandom_range(0, 2);
        for (int i = 0; i < n; i++) step("trap", rb(), rb(), 1'b0, X_TRAP, 1'b0);
        step("trap_clr", rb(), rb(), 1'b1, X_TRAP, 1'b0);
        cur_cause = 2'b00;
    endtask

    // ilat/dlat: waiting cycles before ready; >= TO means ready never arrives in time.
    task automatic run_instr(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7,
                             input int ilat, input int dlat);
        kind_t k;
        logic  timed_out;
        cur_op  = op;
        cur_f3  = f3;
        cur_f7  = f7;
        cur_dec = ref_decode(op, f3, f7);
        k       = classify(op);
        timed_out = 1'b0;
        for (int c = 0; c < TO; c++) begin
            if (c == ilat) begin
                step("fetch", 1'b1, rb(), 1'b0, X_FDONE, 1'b0);
                break;
            end
            step("fetch_wait", 1'b0, rb(), 1'b0, X_FWAIT, 1'b0);
            if (c == TO - 1) timed_out = 1'b1;
        end
        if (timed_out) begin
            do_trap(2'b10);
            return;
        end
        step("decode", rb(), rb(), 1'b0, X_IDLE, 1'b1);
        if (k == K_ILLEGAL) begin
            do_trap(2'b01);
            return;
        end
        if (k == K_PCEXEC) begin
            step("exec", rb(), rb(), 1'b0, X_PC, 1'b1);
            return;
        end
        step("exec", rb(), rb(), 1'b0, X_IDLE, 1'b1);
        if (k == K_WB) begin
            step("wb", rb(), rb(), 1'b0, X_WB, 1'b1);
            return;
        end
        for (int c = 0; c < TO; c++) begin
            if (c == dlat) begin
                step("mem_done", rb(), 1'b1, 1'b0, (k == K_STORE) ? X_STDONE : X_LDMEM, 1'b1);
                break;
            end
            step("mem_wait", rb(), 1'b0, 1'b0, (k == K_STORE) ? X_STMEM : X_LDMEM, 1'b1);
            if (c == TO - 1) timed_out = 1'b1;
        end
        if (timed_out) begin
            do_trap(2'b11);
            return;
        end
        if (k == K_LOAD) step("wb", rb(), rb(), 1'b0, X_WB, 1'b1);
    endtask

    initial begin
        logic [6:0] op_tab [13];
        op_tab = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011, 7'b1100011,
                   7'b1101111, 7'b1100111, 7'b0110111, 7'b0010111, 7'b0001111,
                   7'b0000000, 7'b1110011, 7'b1111111};

        $display("[TB] reset state");
        applyStimulus(1'b1, 1'b1, 1'b0);
        checkOutput("reset", X_FWAIT, dec_t'('0));
        bus.imem_ready = 1'b0;
        bus.dmem_ready = 1'b0;
        @(posedge clk);
        #1 rst = 1'b0;

        $display("[TB] directed instructions");
        run_instr(7'b0110011, 3'b000, 7'b0100000, 2, 0);
        run_instr(7'b0000011, 3'b010, 7'b0000000, 0, 3);
        run_instr(7'b0100011, 3'b000, 7'b0000000, 1, 2);
        run_instr(7'b1100011, 3'b000, 7'b0000000, 0, 0);
        run_instr(7'b0010011, 3'b101, 7'b0100000, 3, 0);
        run_instr(7'b0110111, 3'b000, 7'b0000000, 0, 0);
        run_instr(7'b1101111, 3'b000, 7'b0000000, 0, 0);
        run_instr(7'b1100111, 3'b000, 7'b0000000, 1, 0);
        run_instr(7'b0010111, 3'b000, 7'b0000000, 0, 0);
        run_instr(7'b0001111, 3'b000, 7'b0000000, 0, 0);
        run_instr(7'b0110011, 3'b000, 7'b0000000, 9, 0);
        run_instr(7'b0000000, 3'b000, 7'b0000000, 0, 0);
        run_instr(7'b0000011, 3'b100, 7'b0000000, 0, 9);
        run_instr(7'b0100011, 3'b010, 7'b0000000, 0, 3);

        $display("[TB] randomized instructions");
        for (int n = 0; n < 60; n++) begin
            int sel;
            int il;
            int dl;
            sel = $urandom_range(0, 12);
            il  = ($urandom_range(0, 9) == 0) ? TO + 1 : $urandom_range(0, TO - 1);
            dl  = ($urandom_range(0, 9) == 0) ? TO + 2 : $urandom_range(0, TO - 1);
            run_instr(op_tab[sel], 3'($urandom_range(0, 7)), 7'($urandom_range(0, 127)), il, dl);
        end

        $display("[TB] reset during MEM");
        cur_op  = 7'b0000011;
        cur_f3  = 3'b010;
        cur_f7  = 7'b0000000;
        cur_dec = ref_decode(cur_op, cur_f3, cur_f7);
        step("fetch", 1'b1, 1'b0, 1'b0, X_FDONE, 1'b0);
        step("decode", 1'b0, 1'b0, 1'b0, X_IDLE, 1'b1);
        step("exec", 1'b0, 1'b0, 1'b0, X_IDLE, 1'b1);
        step("mem_wait", 1'b0, 1'b0, 1'b0, X_LDMEM, 1'b1);
        #1 rst = 1'b1;
        exp_ret = '0;
        #1;
        checkOutput("rst_in_mem", X_FWAIT, dec_t'('0));
        @(posedge clk);
        #1 rst = 1'b0;
        run_instr(7'b0110011, 3'b111, 7'b0000000, 0, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
